// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and the native UART byte width.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_LOCKED    = 2'd3
  } state_t;

  localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin selector, purely combinational: the first requester after rr_ptr (wrapping) wins.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    sel,
  output logic               any_valid
);

  logic [ID_W-1:0] idx;

  // Scan farthest-to-nearest so the last hit is the closest requester after rr_ptr.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        sel       = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers; round-robin per byte, packet lock until req_last.
// Accept -> tx_start is 1 clk; producers are held off (ready=0) until tx_done or timeout abort.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 200000,
  parameter int CNT_W       = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  state_t             state_q, state_n;
  logic               lock_q, lock_n;
  logic [ID_W-1:0]    rr_q, rr_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [DATA_W-1:0]  data_q, data_n;
  logic [ID_W-1:0]    grant_q, grant_n;
  logic               err_q, err_n;
  logic [NUM_REQ-1:0] ready_c;
  logic [ID_W-1:0]    sel;
  logic               any_valid;
  logic               expired;
  logic [DATA_W-1:0]  req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_q),
    .sel       (sel),
    .any_valid (any_valid)
  );

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lock_q  <= 1'b0;
      rr_q    <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      lock_q  <= lock_n;
      rr_q    <= rr_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      grant_q <= grant_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    lock_n  = lock_q;
    rr_n    = rr_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    grant_n = grant_q;
    err_n   = 1'b0;
    ready_c = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          ready_c[sel] = 1'b1;
          data_n       = req_bytes[sel];
          grant_n      = sel;
          lock_n       = ~req_last[sel];
          state_n      = ST_START;
        end
      end
      ST_START: begin
        cnt_n   = '0;
        state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // tx_done takes precedence over a coincident expiry
        if (tx_done) begin
          cnt_n = '0;
          if (lock_q) begin
            state_n = ST_LOCKED;
          end else begin
            rr_n    = grant_q;
            state_n = ST_IDLE;
          end
        end else if (expired) begin
          err_n   = 1'b1;
          lock_n  = 1'b0;
          rr_n    = grant_q;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        ready_c[grant_q] = 1'b1;
        if (req_valid[grant_q]) begin
          data_n  = req_bytes[grant_q];
          lock_n  = ~req_last[grant_q];
          state_n = ST_START;
        end else if (expired) begin
          err_n   = 1'b1;
          lock_n  = 1'b0;
          rr_n    = grant_q;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Ready is combinational from req_valid, so force it low while reset is held.
  assign req_ready   = rst ? ready_c : '0;
  assign tx_start    = (state_q == ST_START);
  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a uart_tx model answering tx_done 100 clk after tx_start.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int TO = 300;
  localparam int CW = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             tx_start;
  logic [DW-1:0]    tx_data;
  logic             tx_done;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic             timeout_err;

  int   checks   = 0;
  int   failures = 0;
  logic hang     = 1'b0;
  logic [IW+DW-1:0] sb[$];

  typedef struct {
    logic [NR-1:0] mask;
    int            exp_id;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .ID_W(IW), .TIMEOUT_CYC(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    req_valid[i]        = v;
    req_data[i*DW +: DW] = d;
    req_last[i]         = l;
  endtask

  // Called just after a negedge; returns on the negedge where tx_start should be high.
  task automatic grant(input logic [NR-1:0] exp_rdy, input int id, input logic [DW-1:0] dat);
    logic [NR-1:0] seen;
    seen = '0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (req_ready != 0) begin
        seen = req_ready;
        break;
      end
      @(negedge clk);
    end
    chk("req_ready", 32'(seen), 32'(exp_rdy));
    if (seen != 0) sb.push_back({id[IW-1:0], dat});
    @(negedge clk);
    chk("tx_start_lat", 32'(tx_start), 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (!busy) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // uart_tx model, aborted by the shared reset
  initial begin
    bit aborted;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && tx_start && !hang) begin
        aborted = 1'b0;
        for (int i = 0; i < 99; i++) begin
          @(negedge clk);
          if (!rst) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
        end
      end
    end
  end

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst && tx_start) begin
      logic [IW+DW-1:0] e;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e[DW-1:0]));
        chk("grant_id", 32'(grant_id), 32'(e[IW+DW-1:DW]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic saw_lock, bad0, got_err;
    logic [DW-1:0] b;

    tbl[0] = '{4'b1111, 1};
    tbl[1] = '{4'b1111, 2};
    tbl[2] = '{4'b1111, 3};
    tbl[3] = '{4'b1111, 0};
    tbl[4] = '{4'b1010, 1};
    tbl[5] = '{4'b1010, 3};
    tbl[6] = '{4'b0100, 2};
    tbl[7] = '{4'b0011, 0};
    tbl[8] = '{4'b1001, 3};

    rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    rst = 1'b1;

    // Single byte from requester 0
    set_req(0, 1'b1, 8'h55, 1'b1);
    grant(4'b0001, 0, 8'h55);
    req_valid = '0;
    repeat (50) @(negedge clk);
    chk("single_busy_mid", 32'(busy), 1);
    chk("single_data_hold", 32'(tx_data), 32'h55);
    wait_idle(n);
    chk("single_busy_len", 32'(n), 32'd50);

    // Round-robin table
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < NR; i++) set_req(i, tbl[k].mask[i], 8'((k + 1) * 16 + i), 1'b1);
      b = 8'((k + 1) * 16 + tbl[k].exp_id);
      grant(NR'(1 << tbl[k].exp_id), tbl[k].exp_id, b);
      req_valid = '0;
      wait_idle(n);
      chk("rr_busy_len", 32'(n), 32'd100);
    end

    // Locked packet from requester 1 while requester 2 waits
    set_req(1, 1'b1, 8'hA1, 1'b0);
    set_req(2, 1'b1, 8'hB2, 1'b1);
    grant(4'b0010, 1, 8'hA1);
    set_req(1, 1'b1, 8'hA2, 1'b0);
    grant(4'b0010, 1, 8'hA2);
    set_req(1, 1'b1, 8'hA3, 1'b1);
    grant(4'b0010, 1, 8'hA3);
    set_req(1, 1'b0, 8'h00, 1'b0);
    grant(4'b0100, 2, 8'hB2);
    req_valid = '0;
    wait_idle(n);

    // Hung transmitter
    hang = 1'b1;
    set_req(3, 1'b1, 8'h77, 1'b1);
    set_req(0, 1'b1, 8'h88, 1'b1);
    grant(4'b1000, 3, 8'h77);
    req_valid = 4'b0001;
    n = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk); #1;
      if (timeout_err) begin
        n = k;
        break;
      end
    end
    chk("hang_timeout_cyc", 32'(n), 32'd301);
    chk("hang_busy", 32'(busy), 0);
    hang = 1'b0;
    grant(4'b0001, 0, 8'h88);
    chk("hang_err_pulse", 32'(timeout_err), 0);
    req_valid = '0;
    wait_idle(n);

    // Locked requester stalls after first byte
    set_req(3, 1'b1, 8'h10, 1'b0);
    grant(4'b1000, 3, 8'h10);
    set_req(3, 1'b0, 8'h00, 1'b0);
    set_req(0, 1'b1, 8'h20, 1'b1);
    saw_lock = 1'b0; bad0 = 1'b0; got_err = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk); #1;
      if (req_ready == 4'b1000) saw_lock = 1'b1;
      if (timeout_err) begin
        got_err = 1'b1;
        break;
      end
      if (req_ready[0]) bad0 = 1'b1;
    end
    chk("stall_locked_ready", 32'(saw_lock), 1);
    chk("stall_no_early_req0", 32'(bad0), 0);
    chk("stall_timeout_err", 32'(got_err), 1);
    grant(4'b0001, 0, 8'h20);
    req_valid = '0;
    wait_idle(n);

    // Reset in the middle of WAIT_DONE
    set_req(1, 1'b1, 8'h5A, 1'b1);
    grant(4'b0010, 1, 8'h5A);
    req_valid = '0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    set_req(2, 1'b1, 8'h3C, 1'b1);
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_tx_start", 32'(tx_start), 0);
    chk("mid_rst_tx_data", 32'(tx_data), 0);
    chk("mid_rst_grant_id", 32'(grant_id), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_timeout_err", 32'(timeout_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    grant(4'b0100, 2, 8'h3C);
    req_valid = '0;
    wait_idle(n);
    chk("post_rst_busy_len", 32'(n), 32'd100);
    chk("post_rst_tx_data", 32'(tx_data), 32'h3C);
    chk("post_rst_grant_id", 32'(grant_id), 32'd2);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
